// File: rtl/mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_ctrl
// Description : Sequential scanner in front of a 16:1 bit multiplexer.
//               Steps the 4-bit select through channels 0..15, holds each
//               enabled channel for SETTLE_CYCLES cycles before sampling,
//               assembles the 16 samples into a word and presents it on a
//               valid/ready handshake. One-shot or continuous scanning with
//               a per-channel enable mask captured at the start of each scan.
//
// Parameters  : SETTLE_CYCLES  cycles sel is held before sampling (1..15)
//
// Ports       : clk      in   clock, rising edge
//               rst_n    in   asynchronous active-low reset
//               start    in   begin a scan (honoured only when idle)
//               cont     in   continuous mode, captured with start
//               chan_en  in   16-bit channel enable, captured per scan
//               mux_out  in   multiplexer output bit
//               sel      out  registered multiplexer select
//               data     out  assembled scan word, data[k] from sel==k
//               valid    out  data valid
//               ready    in   downstream accepts when valid && ready
//               busy     out  high whenever not idle
//
// Revision    : 1.0  initial release
// ============================================================================
module mux_scan_ctrl #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        cont,
    input  logic [15:0] chan_en,
    input  logic        mux_out,
    output logic [3:0]  sel,
    output logic [15:0] data,
    output logic        valid,
    input  logic        ready,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] C_SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0] C_LAST_CHAN   = 4'd15;

    state_t      r_state;
    logic [3:0]  r_sel;
    logic [3:0]  r_cnt;
    logic [15:0] r_shadow;
    logic [15:0] r_en;
    logic        r_cont;
    logic [15:0] r_data;
    logic        r_valid;

    state_t      w_state_nxt;
    logic [3:0]  w_sel_nxt;
    logic [3:0]  w_cnt_nxt;
    logic [15:0] w_shadow_nxt;
    logic [15:0] w_en_nxt;
    logic        w_cont_nxt;
    logic [15:0] w_data_nxt;
    logic        w_valid_nxt;
    logic [3:0]  w_sel_inc;
    logic        w_handshake;
    logic        w_launch;

    assign w_sel_inc   = r_sel + 4'd1;
    assign w_handshake = r_valid && ready;

    // A new scan launches from IDLE on start, or back-to-back from DONE on
    // the handshake edge when the job is continuous.
    assign w_launch = ((r_state == ST_IDLE) && start) ||
                      ((r_state == ST_DONE) && w_handshake && r_cont);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_sel    <= 4'd0;
            r_cnt    <= 4'd0;
            r_shadow <= 16'd0;
            r_en     <= 16'd0;
            r_cont   <= 1'b0;
            r_data   <= 16'd0;
            r_valid  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_sel    <= w_sel_nxt;
            r_cnt    <= w_cnt_nxt;
            r_shadow <= w_shadow_nxt;
            r_en     <= w_en_nxt;
            r_cont   <= w_cont_nxt;
            r_data   <= w_data_nxt;
            r_valid  <= w_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_sel_nxt    = r_sel;
        w_cnt_nxt    = r_cnt;
        w_shadow_nxt = r_shadow;
        w_en_nxt     = r_en;
        w_cont_nxt   = r_cont;
        w_data_nxt   = r_data;
        w_valid_nxt  = r_valid;

        case (r_state)
            ST_IDLE: begin
                w_sel_nxt = 4'd0;
            end

            ST_SETTLE: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_SAMPLE;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end

            ST_SAMPLE: begin
                // Disabled channels are forced to 0 regardless of mux_out.
                w_shadow_nxt[r_sel] = mux_out & r_en[r_sel];
                if (r_sel == C_LAST_CHAN) begin
                    w_data_nxt  = w_shadow_nxt;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_sel_nxt = w_sel_inc;
                    if (r_en[w_sel_inc]) begin
                        w_cnt_nxt   = C_SETTLE_LOAD;
                        w_state_nxt = ST_SETTLE;
                    end else begin
                        w_state_nxt = ST_SAMPLE;
                    end
                end
            end

            ST_DONE: begin
                // sel stays at 15 and data/valid hold until accepted.
                if (w_handshake) begin
                    w_valid_nxt = 1'b0;
                    if (!r_cont) begin
                        w_sel_nxt   = 4'd0;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_sel_nxt   = 4'd0;
            end
        endcase

        // Launch overrides the per-state defaults above: capture the job
        // controls, clear the partial word and start at channel 0.
        if (w_launch) begin
            w_cont_nxt   = (r_state == ST_IDLE) ? cont : r_cont;
            w_en_nxt     = chan_en;
            w_sel_nxt    = 4'd0;
            w_shadow_nxt = 16'd0;
            if (chan_en[0]) begin
                w_cnt_nxt   = C_SETTLE_LOAD;
                w_state_nxt = ST_SETTLE;
            end else begin
                w_state_nxt = ST_SAMPLE;
            end
        end
    end

    assign sel   = r_sel;
    assign data  = r_data;
    assign valid = r_valid;
    assign busy  = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_scan_ctrl
// Description : Self-checking bench for mux_scan_ctrl. A multiplexer model
//               drives mux_out from a pattern word, optionally corrupting the
//               bit for one cycle after every select change. Expected words
//               are pattern & enable; expected latency is derived from the
//               number of enabled channels.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mux_scan_ctrl;

    localparam int SETTLE = 2;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        cont;
    logic [15:0] chan_en;
    logic        mux_out;
    logic [3:0]  sel;
    logic [15:0] data;
    logic        valid;
    logic        ready;
    logic        busy;

    int tests = 0;
    int fails = 0;

    mux_scan_ctrl #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .cont    (cont),
        .chan_en (chan_en),
        .mux_out (mux_out),
        .sel     (sel),
        .data    (data),
        .valid   (valid),
        .ready   (ready),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplexer model: output is wrong for the cycle following a select
    // change, so an early sample corrupts the word.
    logic [15:0] pattern = 16'h0000;
    logic [3:0]  sel_d   = 4'd0;
    bit          glitch_en = 1'b1;
    always @(posedge clk) sel_d <= sel;
    assign mux_out = pattern[sel] ^ (glitch_en && (sel != sel_d));

    typedef struct {
        logic [15:0] en;
        logic [15:0] pat;
        logic [15:0] exp_data;
        int          exp_lat;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int ref_lat(input logic [15:0] en);
        int n = 0;
        for (int k = 0; k < 16; k++) if (en[k]) n++;
        return n * (SETTLE + 1) + (16 - n);
    endfunction

    // Assert start for one edge; that edge is edge 0 of the scan.
    task automatic launch(input logic [15:0] en, input logic cont_v);
        @(negedge clk);
        start   = 1'b1;
        chan_en = en;
        cont    = cont_v;
        @(posedge clk);
        #1;
        chk("busy_on_start", busy, 1'b1);
        chk("sel_on_start", sel, 4'd0);
    endtask

    // Count edges after the launch edge until valid; optionally drive junk on
    // start/chan_en/cont while scanning.
    task automatic wait_valid(input string tag, input logic [15:0] exp_d,
                              input int exp_lat, input bit noise);
        int lat = 0;
        while (!valid && lat < 300) begin
            @(negedge clk);
            ready = 1'b0;
            if (noise) begin
                start   = 1'($urandom);
                chan_en = 16'($urandom);
                cont    = 1'($urandom);
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_data"}, data, exp_d);
    endtask

    // Hold ready low for n cycles and confirm nothing moves.
    task automatic backpressure(input string tag, input logic [15:0] exp_d, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            chk({tag, "_bp_valid"}, valid, 1'b1);
            chk({tag, "_bp_data"}, data, exp_d);
            chk({tag, "_bp_sel"}, sel, 4'd15);
        end
    endtask

    task automatic handshake(input string tag, input bit exp_busy);
        @(negedge clk);
        ready = 1'b1;
        @(posedge clk);
        #1;
        ready = 1'b0;
        chk({tag, "_hs_valid"}, valid, 1'b0);
        chk({tag, "_hs_busy"}, busy, exp_busy);
        chk({tag, "_hs_sel"}, sel, 4'd0);
    endtask

    initial begin
        logic [15:0] en;
        logic [15:0] en_next;
        int          guard;

        rst_n   = 1'b0;
        start   = 1'b0;
        cont    = 1'b0;
        chan_en = 16'h0000;
        ready   = 1'b0;

        vecs[0] = '{en: 16'hFFFF, pat: 16'hA5C3, exp_data: 16'hA5C3, exp_lat: 48};
        vecs[1] = '{en: 16'h00FF, pat: 16'hFFFF, exp_data: 16'h00FF, exp_lat: 32};
        vecs[2] = '{en: 16'h0000, pat: 16'hFFFF, exp_data: 16'h0000, exp_lat: 16};
        vecs[3] = '{en: 16'h8001, pat: 16'hFFFF, exp_data: 16'h8001, exp_lat: 20};
        vecs[4] = '{en: 16'hFF00, pat: 16'h1234, exp_data: 16'h1200, exp_lat: 32};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_sel", sel, 4'd0);
        chk("reset_data", data, 16'd0);
        chk("reset_valid", valid, 1'b0);
        chk("reset_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table: one-shot scans.
        for (int v = 0; v < 5; v++) begin
            pattern = vecs[v].pat;
            launch(vecs[v].en, 1'b0);
            wait_valid($sformatf("vec%0d", v), vecs[v].exp_data, vecs[v].exp_lat, 1'b0);
            backpressure($sformatf("vec%0d", v), vecs[v].exp_data, (v == 0) ? 10 : 2);
            handshake($sformatf("vec%0d", v), 1'b0);
        end

        // Mid-scan noise on start/chan_en/cont must not disturb the word.
        pattern = 16'h5AA5;
        launch(16'hF0F0, 1'b0);
        wait_valid("noise", 16'h5AA5 & 16'hF0F0, ref_lat(16'hF0F0), 1'b1);
        handshake("noise", 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("noise_stays_idle", busy, 1'b0);

        // Randomised one-shot scans against the arithmetic model.
        for (int r = 0; r < 20; r++) begin
            en      = 16'($urandom);
            pattern = 16'($urandom);
            launch(en, 1'b0);
            wait_valid($sformatf("rand%0d", r), pattern & en, ref_lat(en), 1'b0);
            backpressure($sformatf("rand%0d", r), pattern & en, $urandom_range(0, 3));
            handshake($sformatf("rand%0d", r), 1'b0);
        end

        // Continuous mode: pattern and enable change between scans; the next
        // scan's channel 0 starts on the handshake edge.
        en      = 16'hFFFF;
        pattern = 16'h1357;
        launch(en, 1'b1);
        for (int s = 0; s < 4; s++) begin
            cont = 1'b0;
            wait_valid($sformatf("cont%0d", s), pattern & en, ref_lat(en), 1'b0);
            backpressure($sformatf("cont%0d", s), pattern & en, 1);
            en_next = (s == 1) ? 16'h0000 : 16'($urandom);
            pattern = 16'($urandom);
            chan_en = en_next;
            en      = en_next;
            handshake($sformatf("cont%0d", s), 1'b1);
        end

        // Asynchronous reset mid-scan once sel reaches 7.
        @(negedge clk);
        chan_en = 16'hFFFF;
        guard = 0;
        while (sel != 4'd7 && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk("reach_sel7", sel, 4'd7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_sel", sel, 4'd0);
        chk("async_rst_data", data, 16'd0);
        chk("async_rst_valid", valid, 1'b0);
        chk("async_rst_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("post_rst_idle", busy, 1'b0);

        pattern = 16'hC33C;
        launch(16'hFFFF, 1'b0);
        wait_valid("after_rst", 16'hC33C, 48, 1'b0);
        handshake("after_rst", 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got stuck expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
